// File: rtl/mac_tx_arb_pkg.sv
// Shared types for the MAC transmit arbiter: FSM states, grant
// encoding, statistics width and a saturating increment helper.
package mac_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v
    );
        logic [STAT_W-1:0] one;
        one = {{(STAT_W-1){1'b0}}, 1'b1};
        return (v == {STAT_W{1'b1}}) ? v : v + one;
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Requester and MAC-side signals of the transmit arbiter.
// slave = arbiter side, master = sources/MAC side.
interface mac_tx_arbiter_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] a_data;
    logic              a_valid;
    logic              a_drop;
    logic [DATA_W-1:0] b_data;
    logic              b_valid;
    logic              b_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;

    modport slave (
        input  a_data, a_valid, b_data, b_valid,
        output a_drop, b_ready, tx_data, tx_valid
    );

    modport master (
        output a_data, a_valid, b_data, b_valid,
        input  a_drop, b_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers for full/empty and
// read data registered on pop.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rd_data_o = rd_data_q;

    // pointer advance and head capture on pop
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rd_data_d = rd_data_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop) begin
            rptr_d    = rptr_q + PTR_ONE;
            rd_data_d = mem_q[rptr_q[AW-1:0]];
        end
    end

    // pointer and read-data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // storage array; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// File: rtl/mac_tx_arbiter.sv
// Round-robin arbiter of A (FIFO) and B (holding register) onto the
// MAC tx port with forced idle spacing. Stats: MAC_TX_ARB_STATS_EN.
module mac_tx_arbiter
    import mac_tx_arb_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int A_DEPTH    = 4,
    parameter int GAP_CYCLES = 400
) (
    input  logic              clk,
    input  logic              rst_n,
    mac_tx_arbiter_if.slave   bus,
    output logic              busy,
    output logic [STAT_W-1:0] stat_sent_a,
    output logic [STAT_W-1:0] stat_sent_b,
    output logic [STAT_W-1:0] stat_drop
);
    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] CNT_ONE  = 16'd1;

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            sel_q, sel_d;
    grant_e            win;
    logic [15:0]       gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;
    logic              b_full_q, b_full_d;
    logic              b_hs, grant_b;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (A_DEPTH)
    ) u_a_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (bus.a_valid),
        .wr_data_i (bus.a_data),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // fullness is the pre-pop view, so a push on full always drops
    assign bus.a_drop   = bus.a_valid && fifo_full;
    assign bus.b_ready  = !b_full_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy = (state_q != IDLE) || !fifo_empty || b_full_q;
    assign b_hs = bus.b_valid && !b_full_q;

    // grant, issue and gap sequencing
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        gap_cnt_d    = gap_cnt_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        fifo_pop     = 1'b0;
        grant_b      = 1'b0;
        win          = GRANT_A;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty || b_full_q) begin
                    if (!fifo_empty &&
                        (!b_full_q || last_grant_q == GRANT_B))
                        win = GRANT_A;
                    else
                        win = GRANT_B;
                    sel_d        = win;
                    last_grant_d = win;
                    fifo_pop     = (win == GRANT_A);
                    grant_b      = (win == GRANT_B);
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                tx_valid_d = 1'b1;
                tx_data_d  = (sel_q == GRANT_A) ? fifo_rd_data
                                                : b_data_q;
                gap_cnt_d  = GAP_LOAD;
                state_d    = GAP;
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else gap_cnt_d = gap_cnt_q - CNT_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // B holding register: loaded on handshake, freed on grant
    always_comb begin
        b_full_d = b_full_q;
        b_data_d = b_data_q;
        if (grant_b) b_full_d = 1'b0;
        if (b_hs) begin
            b_full_d = 1'b1;
            b_data_d = bus.b_data;
        end
    end

    // arbiter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_B;
            sel_q        <= GRANT_B;
            gap_cnt_q    <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            b_data_q     <= '0;
            b_full_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            gap_cnt_q    <= gap_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            b_data_q     <= b_data_d;
            b_full_q     <= b_full_d;
        end
    end

`ifdef MAC_TX_ARB_STATS_EN
    logic [STAT_W-1:0] sent_a_q, sent_b_q, drop_q;

    // saturating per-requester frame and drop counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_a_q <= '0;
            sent_b_q <= '0;
            drop_q   <= '0;
        end else begin
            if (state_q == ISSUE && sel_q == GRANT_A)
                sent_a_q <= sat_inc(sent_a_q);
            if (state_q == ISSUE && sel_q == GRANT_B)
                sent_b_q <= sat_inc(sent_b_q);
            if (bus.a_drop)
                drop_q <= sat_inc(drop_q);
        end
    end

    assign stat_sent_a = sent_a_q;
    assign stat_sent_b = sent_b_q;
    assign stat_drop   = drop_q;
`else
    assign stat_sent_a = '0;
    assign stat_sent_b = '0;
    assign stat_drop   = '0;
`endif
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: directed table, hand sequences and
// random traffic against a queue-based transaction model.
module tb_mac_tx_arbiter;
    import mac_tx_arb_pkg::*;

    localparam int DW    = 128;
    localparam int DEPTH = 4;
    localparam int G     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic [15:0] st_a, st_b, st_d;

    mac_tx_arbiter_if #(.DATA_W(DW)) bus();

    mac_tx_arbiter #(
        .DATA_W     (DW),
        .A_DEPTH    (DEPTH),
        .GAP_CYCLES (G)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .stat_sent_a (st_a),
        .stat_sent_b (st_b),
        .stat_drop   (st_d)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string nm, logic [DW-1:0] act,
                       logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // transaction model: A queue, B slot, earliest next grant edge
    typedef struct {
        int            e;
        logic [DW-1:0] d;
        bit            is_a;
    } frm_t;

    logic [DW-1:0] m_aq[$];
    frm_t          m_fq[$];
    bit            m_bhas;
    logic [DW-1:0] m_bdat;
    bit            m_last_a;
    int            m_free;
    logic [DW-1:0] m_last_data;
    int            m_na, m_nb, m_ndrop;
    int            cyc = 0;

    int obs_drops, obs_tx;
    int strobe_cyc[$];
    bit gseq[$];

    function automatic void model_clear();
        m_aq.delete();
        m_fq.delete();
        m_bhas      = 1'b0;
        m_bdat      = '0;
        m_last_a    = 1'b0;
        m_free      = 0;
        m_last_data = '0;
        m_na        = 0;
        m_nb        = 0;
        m_ndrop     = 0;
    endfunction

    task automatic chk_stats();
`ifdef MAC_TX_ARB_STATS_EN
        chk("stat_sent_a", DW'(st_a), DW'(16'(m_na)));
        chk("stat_sent_b", DW'(st_b), DW'(16'(m_nb)));
        chk("stat_drop", DW'(st_d), DW'(16'(m_ndrop)));
`else
        chk("stat_sent_a", DW'(st_a), '0);
        chk("stat_sent_b", DW'(st_b), '0);
        chk("stat_drop", DW'(st_d), '0);
`endif
    endtask

    // one clock: drive, check pre-edge, advance model, check post-edge
    task automatic tick(bit av, logic [DW-1:0] ad,
                        bit bv, logic [DW-1:0] bd);
        bit            full_pre, exp_drop, hs_b, pick_a, exp_busy;
        logic [DW-1:0] d;
        frm_t          nf, f;
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
        #1;
        full_pre = (m_aq.size() == DEPTH);
        exp_drop = av && full_pre;
        chk("a_drop", DW'(bus.a_drop), DW'(exp_drop));
        chk("b_ready", DW'(bus.b_ready), DW'(!m_bhas));
        if (bus.a_drop) obs_drops++;
        hs_b = bv && !m_bhas;
        if (cyc >= m_free && (m_aq.size() > 0 || m_bhas)) begin
            pick_a = (m_aq.size() > 0) && (!m_bhas || !m_last_a);
            if (pick_a) d = m_aq.pop_front();
            else begin
                d = m_bdat;
                m_bhas = 1'b0;
            end
            m_last_a = pick_a;
            nf.e = cyc + 1;
            nf.d = d;
            nf.is_a = pick_a;
            m_fq.push_back(nf);
            m_free = cyc + G + 2;
        end
        if (av && !full_pre) m_aq.push_back(ad);
        if (exp_drop) m_ndrop++;
        if (hs_b) begin
            m_bhas = 1'b1;
            m_bdat = bd;
        end
        @(posedge clk);
        @(negedge clk);
        if (bus.tx_valid) begin
            obs_tx++;
            strobe_cyc.push_back(cyc);
        end
        if (m_fq.size() > 0 && m_fq[0].e == cyc) begin
            f = m_fq.pop_front();
            chk("tx_valid", DW'(bus.tx_valid), DW'(1));
            m_last_data = f.d;
            if (f.is_a) m_na++;
            else m_nb++;
            gseq.push_back(f.is_a);
        end else begin
            chk("tx_valid", DW'(bus.tx_valid), DW'(0));
        end
        chk("tx_data", bus.tx_data, m_last_data);
        exp_busy = (cyc < m_free - 1) || (m_aq.size() > 0) || m_bhas;
        chk("busy", DW'(busy), DW'(exp_busy));
        chk_stats();
        cyc++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // directed tie case: {inputs, expected outputs after the edge}
    typedef struct {
        bit av;
        bit bv;
        bit txv;
        int dsel;
        bit brdy;
        bit bsy;
    } vec_t;

    vec_t tbl[14];
    logic [DW-1:0] DA = {4{32'hA5A5A5A5}};
    logic [DW-1:0] DB = {4{32'h0B0B_C0DE}};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ed;
        int n_load, reps;

        tbl[0] = '{1, 1, 0, 0, 0, 1};
        tbl[1] = '{0, 0, 0, 0, 0, 1};
        tbl[2] = '{0, 0, 1, 1, 0, 1};
        for (int i = 3; i < 7; i++) tbl[i] = '{0, 0, 0, 1, 0, 1};
        tbl[7] = '{0, 0, 0, 1, 1, 1};
        tbl[8] = '{0, 0, 1, 2, 1, 1};
        for (int i = 9; i < 12; i++) tbl[i] = '{0, 0, 0, 2, 1, 1};
        tbl[12] = '{0, 0, 0, 2, 1, 0};
        tbl[13] = '{0, 0, 0, 2, 1, 0};

        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_data  = '0;
        obs_drops = 0;
        obs_tx = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_tx_valid", DW'(bus.tx_valid), '0);
        chk("rst_tx_data", bus.tx_data, '0);
        chk("rst_a_drop", DW'(bus.a_drop), '0);
        chk("rst_b_ready", DW'(bus.b_ready), DW'(1));
        chk("rst_busy", DW'(busy), '0);
        chk_stats();

        // A and B tied from reset: A first, B G+2 cycles later
        for (int i = 0; i < 14; i++) begin
            bus.a_valid = tbl[i].av;
            bus.a_data  = DA;
            bus.b_valid = tbl[i].bv;
            bus.b_data  = DB;
            @(posedge clk);
            @(negedge clk);
            ed = (tbl[i].dsel == 0) ? '0 :
                 (tbl[i].dsel == 1) ? DA : DB;
            chk($sformatf("tbl%0d_tx_valid", i),
                DW'(bus.tx_valid), DW'(tbl[i].txv));
            chk($sformatf("tbl%0d_tx_data", i), bus.tx_data, ed);
            chk($sformatf("tbl%0d_b_ready", i),
                DW'(bus.b_ready), DW'(tbl[i].brdy));
            chk($sformatf("tbl%0d_busy", i),
                DW'(busy), DW'(tbl[i].bsy));
        end

        // single A push: strobe two edges after the push edge
        do_reset();
        strobe_cyc.delete();
        begin
            int c0;
            c0 = cyc;
            tick(1'b1, DA, 1'b0, '0);
            idle(14);
            chk("single_strobes", DW'(strobe_cyc.size()), DW'(1));
            if (strobe_cyc.size() > 0)
                chk("single_latency", DW'(strobe_cyc[0] - c0), DW'(2));
        end

        // six pushes during a gap: last two drop, one on a pop edge
        do_reset();
        obs_drops = 0;
        obs_tx = 0;
        strobe_cyc.delete();
        tick(1'b1, rnd128(), 1'b0, '0);
        idle(1);
        for (int k = 0; k < 6; k++) tick(1'b1, rnd128(), 1'b0, '0);
        idle(40);
        chk("burst_drops", DW'(obs_drops), DW'(2));
        chk("burst_frames", DW'(obs_tx), DW'(5));
        for (int i = 1; i < strobe_cyc.size(); i++)
            chk("burst_spacing",
                DW'(strobe_cyc[i] - strobe_cyc[i-1]), DW'(G + 2));

        // both continuously pending: strict alternation, A first
        do_reset();
        gseq.delete();
        for (int k = 0; k < 60; k++)
            tick(1'b1, rnd128(), 1'b1, rnd128());
        n_load = gseq.size();
        idle(60);
        chk("alt_frames", DW'(n_load >= 8), DW'(1));
        if (n_load > 0) chk("alt_first_a", DW'(gseq[0]), DW'(1));
        reps = 0;
        for (int i = 1; i < n_load; i++)
            if (gseq[i] == gseq[i-1]) reps++;
        chk("alt_repeats", DW'(reps), '0);

        // async reset mid-gap with three A entries and B pending
        do_reset();
        tick(1'b1, rnd128(), 1'b1, rnd128());
        tick(1'b1, rnd128(), 1'b0, '0);
        tick(1'b1, rnd128(), 1'b0, '0);
        tick(1'b1, rnd128(), 1'b0, '0);
        chk("pre_rst_busy", DW'(busy), DW'(1));
        chk("pre_rst_b_ready", DW'(bus.b_ready), '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", DW'(bus.tx_valid), '0);
        chk("mid_rst_tx_data", bus.tx_data, '0);
        chk("mid_rst_b_ready", DW'(bus.b_ready), DW'(1));
        chk("mid_rst_busy", DW'(busy), '0);
        chk("mid_rst_a_drop", DW'(bus.a_drop), '0);
        model_clear();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        obs_tx = 0;
        idle(20);
        chk("post_rst_frames", DW'(obs_tx), '0);

        // random mixed traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++)
            tick($urandom_range(0, 99) < 30, rnd128(),
                 $urandom_range(0, 99) < 25, rnd128());
        idle(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Shares the single MAC transmit port (128-bit payload, single-cycle `tx_valid` strobe, no back-pressure) between two requesters. Requester A is the validator hash output, push-only and buffered in a small FIFO. Requester B is a status/debug source with a valid/ready handshake. The block sits between those sources and the MAC wrapper's `tx_data_i`/`tx_valid_i` in the `clk` domain. It grants round-robin and enforces a minimum spacing between frames so the RMII serializer is never overrun.

## Interface
- `DATA_W`, 128, payload width of all data ports
- `A_DEPTH`, 4, requester-A FIFO entries; power of two, ≥2
- `GAP_CYCLES`, 400, idle `clk` cycles forced after every issued frame; ≥1, fits 16 bits
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  asynchronous active-low reset
- `a_data`  in  DATA_W  requester A payload
- `a_valid`  in  1  requester A push strobe; no ready
- `a_drop`  out  1  one-cycle pulse: A push discarded because FIFO full
- `b_data`  in  DATA_W  requester B payload
- `b_valid`  in  1  requester B valid
- `b_ready`  out  1  B holding register empty; transfer when `b_valid && b_ready`
- `tx_data`  out  DATA_W  payload to MAC, registered
- `tx_valid`  out  1  one-cycle frame strobe to MAC
- `busy`  out  1  high whenever state ≠ IDLE or any request pending
- `stat_sent_a`, `stat_sent_b`, `stat_drop`  out  16 each  saturating counters (see Configuration)

## Operation
- Requester A: a push while FIFO not full is stored. A push while full is dropped with `a_drop`=1 that cycle. Fullness is evaluated before a same-cycle pop, so a push on a full FIFO is dropped even if a pop occurs in that cycle.
- Requester B: single holding register. `b_ready` = register empty. A handshake loads it. It is cleared on grant.
- FSM states:
  - IDLE: if A pending or B pending, select winner, register `tx_data`, pop winner, update `last_grant`, go to ISSUE; otherwise stay.
  - ISSUE: `tx_valid`=1 for exactly this cycle; load gap counter with GAP_CYCLES−1; go to GAP.
  - GAP: decrement counter; at 0 go to IDLE.
- Arbitration: if only one requester is pending, it wins. If both are pending, the winner is the one not in `last_grant`. `last_grant` resets to B, so A wins the first tie.
- Reset (asynchronous, any state): FSM→IDLE, FIFO empty, B register empty, `last_grant`=B, counters 0. All outputs drop immediately. In-flight and queued frames are discarded without notification.
- Reset values: `tx_valid`=0, `tx_data`=0, `a_drop`=0, `b_ready`=1 once `rst_n` is high, `busy`=0, all stats 0.

## Timing
- Latency: A push or B handshake at edge n with block idle and gap expired gives `tx_valid` high in the cycle after edge n+2. The entry is visible at n+1 (IDLE grants) and ISSUE follows at n+2.
- Minimum `tx_valid` spacing: exactly GAP_CYCLES+2 cycles between strobe rising edges under continuous load.
- `b_ready` rises the cycle after the grant edge. A new B handshake is accepted during ISSUE/GAP.
- `tx_data` holds its last issued value between strobes. It is valid only while `tx_valid`=1.
- A FIFO wrap-around: read/write pointers carry one extra bit for full/empty detection. Simultaneous push and pop on a non-full FIFO keeps the occupancy constant.

## Configuration
- `MAC_TX_ARB_STATS_EN` defined:
  - `stat_sent_a`/`stat_sent_b` increment on each ISSUE for the respective grant.
  - `stat_drop` increments on each `a_drop`.
  - All three saturate at 16'hFFFF.
  - All three clear only on reset.
- Not defined: the three stat ports remain present and are tied to 0. No counter logic is synthesized.

## Structure
- Package `mac_tx_arb_pkg`:
  - FSM state enum (IDLE, ISSUE, GAP)
  - grant encoding (GRANT_A, GRANT_B)
  - stat counter width constant (16)
- Sub-module `sync_fifo` (parameterized width/depth, same `clk`/`rst_n`, full/empty flags, registered read data on pop) implements requester A storage. The arbiter FSM, B register and gap counter live in the top module.

## Test plan
- Single A push 128'hA5…A5 after reset → `tx_valid` one cycle after edge n+2 with `tx_data`=128'hA5…A5; next strobe impossible before GAP_CYCLES+2 cycles.
- A and B both pending in the same cycle from reset → A issued first, B issued exactly GAP_CYCLES+2 cycles later. Repeat with both continuously pending → strict alternation A,B,A,B.
- GAP_CYCLES=4, 6 back-to-back A pushes with A_DEPTH=4 during a gap → pushes 5 and 6 produce `a_drop` pulses; 4 frames issued in order, 6 cycles apart.
- Push on full FIFO in the same cycle the FSM pops → push dropped, `a_drop`=1, occupancy becomes depth−1.
- Assert `rst_n`=0 mid-GAP with A FIFO holding 3 entries → `tx_valid`=0 immediately; after release no frame issues; `b_ready`=1.
- With `MAC_TX_ARB_STATS_EN`: 3 A frames, 2 B frames, 1 drop → stats 3/2/1. Force `stat_drop` to 16'hFFFF via 65 536 drops → stays 16'hFFFF. Without the macro → all stats 0.
